apb_fll_cfg_master: RTL and testbench



---
 rtl/apb_fll_pkg.sv | 24 ++
 rtl/apb_fll_cfg_master_sync_ff.sv | 23 ++
 rtl/apb_fll_cfg_master.sv | 162 ++++++++++++++++
 tb/tb_apb_fll_cfg_master.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_fll_pkg.sv
// Shared types and constants for the APB-to-FLL configuration requester.
package apb_fll_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACKLOW,
    DONE,
    ERR
  } fll_cfg_state_e;

  localparam logic [2:0] FLL_REG0   = 3'd0;
  localparam logic [2:0] FLL_REG1   = 3'd1;
  localparam logic [2:0] FLL_REG2   = 3'd2;
  localparam logic [2:0] FLL_REG3   = 3'd3;
  localparam logic [2:0] FLL_STATUS = 3'd4;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_0F11;

  function automatic logic is_fll_reg(input logic [2:0] idx);
    return (idx <= FLL_REG3);
  endfunction

endpackage

// File: rtl/apb_fll_cfg_master_sync_ff.sv
// Multi-stage reset-to-zero synchronizer for single-bit asynchronous inputs.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/apb_fll_cfg_master.sv
// APB slave that turns each FLL register access into one 4-phase req/ack
// handshake with per-phase timeout, plus a lock status register.
module apb_fll_cfg_master
  import apb_fll_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [31:0]               pwdata_i,
  input  logic                      pwrite_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic                      fll_req_o,
  output logic                      fll_wrn_o,
  output logic [1:0]                fll_add_o,
  output logic [31:0]               fll_data_o,
  input  logic                      fll_ack_i,
  input  logic [31:0]               fll_r_data_i,
  input  logic                      fll_lock_i,
  output logic                      lock_lost_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

  fll_cfg_state_e state_q, state_d;
  logic           req_q, req_d;
  logic           wrn_q, wrn_d;
  logic [1:0]     add_q, add_d;
  logic [31:0]    data_q, data_d;
  logic [31:0]    prdata_q, prdata_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic           lock_lost_q, lock_lost_d;
  logic           lock_prev_q;

  logic           ack_s, lock_s;
  logic [2:0]     addr_idx;
  logic           access, idle_access, is_fll, is_status;
  logic           lock_fall, w1c;
  logic [31:0]    status_word;
  logic           unused_addr_bits;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (fll_ack_i),
    .q_o    (ack_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (fll_lock_i),
    .q_o    (lock_s)
  );

  assign addr_idx         = paddr_i[4:2];
  assign unused_addr_bits = ^{paddr_i[APB_ADDR_WIDTH-1:5], paddr_i[1:0]};
  assign access           = psel_i & penable_i;
  assign idle_access      = (state_q == IDLE) & access;
  assign is_fll           = is_fll_reg(addr_idx);
  assign is_status        = (addr_idx == FLL_STATUS);
  assign status_word      = {30'b0, lock_lost_q, lock_s};

  // Loss-of-lock capture beats a same-cycle write-one-to-clear.
  assign lock_fall   = lock_prev_q & ~lock_s;
  assign w1c         = idle_access & is_status & pwrite_i & pwdata_i[1];
  assign lock_lost_d = lock_fall | (lock_lost_q & ~w1c);

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    wrn_d    = wrn_q;
    add_d    = add_q;
    data_d   = data_q;
    prdata_d = prdata_q;
    cnt_d    = '0;
    cnt_inc  = cnt_q + CW'(1);

    unique case (state_q)
      IDLE: begin
        // A stale ack left over from an aborted handshake blocks new requests.
        if (idle_access && is_fll && !ack_s) begin
          add_d   = addr_idx[1:0];
          wrn_d   = ~pwrite_i;
          data_d  = pwdata_i;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          if (wrn_q) prdata_d = fll_r_data_i;
          req_d   = 1'b0;
          state_d = ACKLOW;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          req_d    = 1'b0;
          prdata_d = ERR_RDATA;
          state_d  = ERR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ACKLOW: begin
        if (!ack_s) begin
          state_d = DONE;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          prdata_d = ERR_RDATA;
          state_d  = ERR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      wrn_q       <= 1'b1;
      add_q       <= '0;
      data_q      <= '0;
      prdata_q    <= '0;
      cnt_q       <= '0;
      lock_lost_q <= 1'b0;
      lock_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      wrn_q       <= wrn_d;
      add_q       <= add_d;
      data_q      <= data_d;
      prdata_q    <= prdata_d;
      cnt_q       <= cnt_d;
      lock_lost_q <= lock_lost_d;
      lock_prev_q <= lock_s;
    end
  end

  // STATUS and unmapped accesses complete combinationally in the first access cycle.
  assign pready_o   = (state_q == DONE) | (state_q == ERR) | (idle_access & ~is_fll);
  assign pslverr_o  = (state_q == ERR) | (idle_access & ~is_fll & ~is_status);
  assign prdata_o   = (idle_access && is_status && !pwrite_i) ? status_word : prdata_q;

  assign fll_req_o   = req_q;
  assign fll_wrn_o   = wrn_q;
  assign fll_add_o   = add_q;
  assign fll_data_o  = data_q;
  assign lock_lost_o = lock_lost_q;

endmodule

// File: tb/tb_apb_fll_cfg_master.sv
// Directed bench for apb_fll_cfg_master with an FLL responder model and an APB scoreboard.
module tb_apb_fll_cfg_master;
  import apb_fll_pkg::*;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [11:0] paddr_i;
  logic [31:0] pwdata_i;
  logic        pwrite_i, psel_i, penable_i;
  logic [31:0] prdata_o;
  logic        pready_o, pslverr_o;
  logic        fll_req_o, fll_wrn_o;
  logic [1:0]  fll_add_o;
  logic [31:0] fll_data_o;
  logic        fll_ack_i;
  logic [31:0] fll_r_data_i;
  logic        fll_lock_i;
  logic        lock_lost_o;

  always #5 clk_i = ~clk_i;

  apb_fll_cfg_master #(
    .APB_ADDR_WIDTH (12),
    .SYNC_STAGES    (2),
    .TIMEOUT        (8)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .paddr_i      (paddr_i),
    .pwdata_i     (pwdata_i),
    .pwrite_i     (pwrite_i),
    .psel_i       (psel_i),
    .penable_i    (penable_i),
    .prdata_o     (prdata_o),
    .pready_o     (pready_o),
    .pslverr_o    (pslverr_o),
    .fll_req_o    (fll_req_o),
    .fll_wrn_o    (fll_wrn_o),
    .fll_add_o    (fll_add_o),
    .fll_data_o   (fll_data_o),
    .fll_ack_i    (fll_ack_i),
    .fll_r_data_i (fll_r_data_i),
    .fll_lock_i   (fll_lock_i),
    .lock_lost_o  (lock_lost_o)
  );

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Responder: acks ack_dly cycles after req, releases rel_dly cycles after req drops.
  logic        manual = 1'b0;
  logic        man_ack = 1'b0;
  logic        rsp_ack;
  logic        unstable = 1'b0;
  int          ack_dly = 3;
  int          rel_dly = 2;
  logic [31:0] rsp_data = '0;
  logic [1:0]  snap_add = '0;
  logic        snap_wrn = 1'b0;
  logic [31:0] snap_data = '0;
  int          req_rises = 0;
  int          req_hi_cycles = 0;

  assign fll_ack_i = manual ? man_ack : rsp_ack;

  always @(posedge fll_req_o) req_rises++;
  always @(negedge clk_i) if (fll_req_o) req_hi_cycles++;

  initial begin
    rsp_ack = 1'b0;
    fll_r_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (fll_req_o && !manual) begin
        snap_add  = fll_add_o;
        snap_wrn  = fll_wrn_o;
        snap_data = fll_data_o;
        for (int i = 1; i < ack_dly; i++) begin
          @(negedge clk_i);
          if (fll_add_o !== snap_add || fll_wrn_o !== snap_wrn || fll_data_o !== snap_data || fll_req_o !== 1'b1)
            unstable = 1'b1;
        end
        fll_r_data_i = rsp_data;
        rsp_ack = 1'b1;
        for (int i = 0; i < 1000 && fll_req_o; i++) begin
          if (fll_add_o !== snap_add || fll_wrn_o !== snap_wrn || fll_data_o !== snap_data)
            unstable = 1'b1;
          @(negedge clk_i);
        end
        repeat (rel_dly) @(negedge clk_i);
        rsp_ack = 1'b0;
        fll_r_data_i = '0;
      end
    end
  end

  task automatic apb_start(input string tag, input logic [11:0] addr, input logic [31:0] wdata,
                           input logic write, input logic chk_rdata, input logic [31:0] rdata,
                           input logic err);
    exp_t e;
    e.tag = tag; e.rdata = rdata; e.chk_rdata = chk_rdata; e.err = err;
    exp_q.push_back(e);
    @(negedge clk_i);
    paddr_i   = addr;
    pwdata_i  = wdata;
    pwrite_i  = write;
    psel_i    = 1'b1;
    penable_i = 1'b0;
    @(negedge clk_i);
    penable_i = 1'b1;
    #1;
  endtask

  task automatic apb_finish();
    logic        seen;
    logic [31:0] rd;
    logic        er;
    exp_t        e;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (pready_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_i);
      #1;
    end
    rd = prdata_o;
    er = pslverr_o;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_underflow observed=empty expected=entry");
    end else begin
      e = exp_q.pop_front();
      check({e.tag, "_pready"}, {31'b0, seen}, 32'd1);
      check({e.tag, "_pslverr"}, {31'b0, er}, {31'b0, e.err});
      if (e.chk_rdata) check({e.tag, "_prdata"}, rd, e.rdata);
    end
    @(negedge clk_i);
    psel_i    = 1'b0;
    penable_i = 1'b0;
    pwrite_i  = 1'b0;
    #1;
    check("pready_single_pulse", {31'b0, pready_o}, 32'd0);
  endtask

  initial begin
    int r0;
    logic stale_pready;
    rstn_i = 1'b0;
    paddr_i = '0; pwdata_i = '0; pwrite_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
    fll_lock_i = 1'b0;

    repeat (3) @(negedge clk_i);
    check("rst_req",       {31'b0, fll_req_o},   32'd0);
    check("rst_wrn",       {31'b0, fll_wrn_o},   32'd1);
    check("rst_add",       {30'b0, fll_add_o},   32'd0);
    check("rst_data",      fll_data_o,           32'd0);
    check("rst_prdata",    prdata_o,             32'd0);
    check("rst_pready",    {31'b0, pready_o},    32'd0);
    check("rst_pslverr",   {31'b0, pslverr_o},   32'd0);
    check("rst_lock_lost", {31'b0, lock_lost_o}, 32'd0);
    rstn_i = 1'b1;

    // FLL write to register 2
    rsp_data = 32'h0BAD_BEEF;
    unstable = 1'b0;
    apb_start("wr_reg2", 12'h008, 32'h0000_1234, 1'b1, 1'b0, 32'h0, 1'b0);
    apb_finish();
    check("wr_add",    {30'b0, snap_add},  32'd2);
    check("wr_wrn",    {31'b0, snap_wrn},  32'd0);
    check("wr_data",   snap_data,          32'h0000_1234);
    check("wr_stable", {31'b0, unstable},  32'd0);

    // FLL read from register 1
    rsp_data = 32'hCAFE_F00D;
    unstable = 1'b0;
    apb_start("rd_reg1", 12'h004, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
    apb_finish();
    check("rd_add",    {30'b0, snap_add},  32'd1);
    check("rd_wrn",    {31'b0, snap_wrn},  32'd1);
    check("rd_stable", {31'b0, unstable},  32'd0);
    check("rd_hold",   prdata_o,           32'hCAFE_F00D);

    // Responder never acks: timeout after 8 REQ cycles
    manual = 1'b1;
    man_ack = 1'b0;
    req_hi_cycles = 0;
    apb_start("timeout", 12'h000, 32'h0, 1'b0, 1'b1, ERR_RDATA, 1'b1);
    apb_finish();
    check("timeout_req_cycles", req_hi_cycles, 32'd8);

    // Stale ack after the abort holds off the next request
    man_ack = 1'b1;
    repeat (4) @(negedge clk_i);
    r0 = req_rises;
    stale_pready = 1'b0;
    rsp_data = 32'h1111_2222;
    apb_start("stale_ack", 12'h00C, 32'h0, 1'b0, 1'b1, 32'h1111_2222, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (pready_o) stale_pready = 1'b1;
      @(negedge clk_i);
      #1;
    end
    check("stale_no_req",    req_rises,               r0);
    check("stale_no_pready", {31'b0, stale_pready},   32'd0);
    man_ack = 1'b0;
    manual  = 1'b0;
    apb_finish();
    check("stale_one_req",   req_rises,               r0 + 1);

    // Lock status and sticky loss-of-lock
    @(negedge clk_i);
    fll_lock_i = 1'b1;
    repeat (5) @(negedge clk_i);
    apb_start("status_locked", 12'h010, 32'h0, 1'b0, 1'b1, 32'h1, 1'b0);
    apb_finish();
    check("no_lock_lost", {31'b0, lock_lost_o}, 32'd0);
    fll_lock_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check("lock_lost_set", {31'b0, lock_lost_o}, 32'd1);
    apb_start("status_lost", 12'h010, 32'h0, 1'b0, 1'b1, 32'h2, 1'b0);
    apb_finish();
    apb_start("status_w1c", 12'h010, 32'h2, 1'b1, 1'b0, 32'h0, 1'b0);
    apb_finish();
    apb_start("status_cleared", 12'h010, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    apb_finish();
    check("lock_lost_clr", {31'b0, lock_lost_o}, 32'd0);
    fll_lock_i = 1'b1;
    repeat (5) @(negedge clk_i);
    apb_start("status_relock", 12'h010, 32'h0, 1'b0, 1'b1, 32'h1, 1'b0);
    apb_finish();
    // Lock fall reaches the edge detector in the same cycle as the W1C access
    @(negedge clk_i);
    fll_lock_i = 1'b0;
    apb_start("status_w1c_race", 12'h010, 32'h2, 1'b1, 1'b0, 32'h0, 1'b0);
    apb_finish();
    repeat (3) @(negedge clk_i);
    check("set_beats_clr", {31'b0, lock_lost_o}, 32'd1);
    apb_start("status_after_race", 12'h010, 32'h0, 1'b0, 1'b1, 32'h2, 1'b0);
    apb_finish();

    // Unmapped address: zero-wait error, no FLL request
    r0 = req_rises;
    apb_start("bad_addr", 12'h018, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    apb_finish();
    repeat (5) @(negedge clk_i);
    check("bad_addr_no_req", req_rises, r0);

    // Reset in the middle of a handshake
    manual = 1'b1;
    man_ack = 1'b0;
    apb_start("reset_mid", 12'h000, 32'h5555_AAAA, 1'b1, 1'b0, 32'h0, 1'b0);
    repeat (3) @(negedge clk_i);
    check("req_before_reset", {31'b0, fll_req_o}, 32'd1);
    rstn_i = 1'b0;
    #1;
    check("reset_req_drop", {31'b0, fll_req_o}, 32'd0);
    check("reset_state",    32'(dut.state_q),   32'(IDLE));
    check("reset_data",     fll_data_o,         32'd0);
    void'(exp_q.pop_front());
    psel_i = 1'b0;
    penable_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    manual = 1'b0;
    repeat (2) @(negedge clk_i);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
